// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit issuing byte-enabled word accesses, splitting word-crossing requests
module dmem_lsu #(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [2:0]                 req_funct3_i,
    input  logic [31:0]                req_addr_i,
    input  logic [31:0]                req_wdata_i,
    output logic                       resp_valid_o,
    output logic [31:0]                resp_rdata_o,
    output logic                       resp_err_o,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic                       dmem_write_o,
    output logic                       dmem_read_o,
    output logic [3:0]                 dmem_size_o,
    output logic [31:0]                dmem_din_o,
    input  logic [31:0]                dmem_dout_i
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t state_q, state_d;
    logic we_q;
    logic [2:0] f3_q;
    logic [31:0] addr_q, wdata_q, lo_q;
    logic [1:0] off;
    logic [2:0] n;
    logic legal, range_err, err, split;
    logic [7:0] m8;
    logic [63:0] w64, r64, d64;
    logic [31:0] ld;
    logic [DMEM_ADDR_WIDTH-1:0] base;
    assign off = addr_q[1:0];
    assign n = f3_q[1:0] == 2'b00 ? 3'd1 : f3_q[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign legal = we_q ? (!f3_q[2] && f3_q[1:0] != 2'b11) : (f3_q[1:0] != 2'b11 && !(f3_q[2] && f3_q[1]));
    assign range_err = {1'b0, addr_q} + 33'(n) - 33'd1 >= 33'(DMEM_DEPTH * 4);
    assign err = !legal || range_err;
    assign m8 = (n == 3'd1 ? 8'h01 : n == 3'd2 ? 8'h03 : 8'h0f) << off;
    assign split = |m8[7:4];
    assign w64 = {32'b0, wdata_q} << {off, 3'b000};
    // lo_q holds the first word of a split load; dout now holds the second
    assign r64 = split ? {dmem_dout_i, lo_q} : {32'b0, dmem_dout_i};
    assign d64 = r64 >> {off, 3'b000};
    assign ld = f3_q == 3'b000 ? {{24{d64[7]}}, d64[7:0]} :
                f3_q == 3'b001 ? {{16{d64[15]}}, d64[15:0]} :
                f3_q == 3'b100 ? {24'b0, d64[7:0]} :
                f3_q == 3'b101 ? {16'b0, d64[15:0]} : d64[31:0];
    assign base = {addr_q[DMEM_ADDR_WIDTH-1:2], 2'b00};
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == ACC1 && !we_q) lo_q <= dmem_dout_i;
        end
    end
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        dmem_addr_o  = '0;
        dmem_write_o = 1'b0;
        dmem_read_o  = 1'b0;
        dmem_size_o  = '0;
        dmem_din_o   = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                state_d     = req_valid_i ? ACC0 : IDLE;
            end
            ACC0: begin
                state_d = (!err && split) ? ACC1 : RESP;
                if (!err) begin
                    dmem_addr_o  = base;
                    dmem_write_o = we_q;
                    dmem_read_o  = !we_q;
                    dmem_size_o  = m8[3:0];
                    dmem_din_o   = w64[31:0];
                end
            end
            ACC1: begin
                state_d      = RESP;
                dmem_addr_o  = base + DMEM_ADDR_WIDTH'(4);
                dmem_write_o = we_q;
                dmem_read_o  = !we_q;
                dmem_size_o  = m8[7:4];
                dmem_din_o   = w64[63:32];
            end
            default: begin
                state_d      = IDLE;
                resp_valid_o = 1'b1;
                resp_err_o   = err;
                resp_rdata_o = (err || we_q) ? 32'b0 : ld;
            end
        endcase
        if (rst_i) begin
            req_ready_o  = 1'b0;
            resp_valid_o = 1'b0;
            resp_rdata_o = '0;
            resp_err_o   = 1'b0;
            dmem_addr_o  = '0;
            dmem_write_o = 1'b0;
            dmem_read_o  = 1'b0;
            dmem_size_o  = '0;
            dmem_din_o   = '0;
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: byte-level memory model predicts every cycle of dmem_lsu outputs under directed and random requests
module tb_dmem_lsu;
    localparam int DEPTH = 1024;
    localparam int AW = 12;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_f3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, resp_err, dmem_write, dmem_read;
    logic [31:0] resp_rdata, dmem_din, dout;
    logic [AW-1:0] dmem_addr;
    logic [3:0] dmem_size;
    always #5 clk = ~clk;
    dmem_lsu #(.DMEM_DEPTH(DEPTH), .DMEM_ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .dmem_addr_o(dmem_addr), .dmem_write_o(dmem_write), .dmem_read_o(dmem_read),
        .dmem_size_o(dmem_size), .dmem_din_o(dmem_din), .dmem_dout_i(dout)
    );
    typedef struct {logic rdy, wr, rd, rv, err; logic [AW-1:0] addr; logic [3:0] size; logic [31:0] din, rdata;} rec_t;
    typedef struct {logic wr; logic [AW-1:0] addr; logic [3:0] size; logic [31:0] din;} acc_t;
    rec_t exp_q[$];
    acc_t acc_log[$];
    logic [7:0] ref_mem [DEPTH*4];
    logic [31:0] mem [DEPTH];
    logic fill = 1'b1;
    bit chk_en = 1'b0;
    int total = 0, bad = 0;
    logic [31:0] last_rdata = '0;
    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A1234;
    endfunction
    function automatic rec_t blank(logic rdy);
        rec_t r;
        r.rdy = rdy; r.wr = 0; r.rd = 0; r.rv = 0; r.err = 0;
        r.addr = '0; r.size = '0; r.din = '0; r.rdata = '0;
        return r;
    endfunction
    function automatic logic [31:0] extend(logic [2:0] f3, logic [31:0] v);
        case (f3)
            3'd0: return {{24{v[7]}}, v[7:0]};
            3'd1: return {{16{v[15]}}, v[15:0]};
            3'd4: return {24'b0, v[7:0]};
            3'd5: return {16'b0, v[15:0]};
            default: return v;
        endcase
    endfunction
    function automatic logic [31:0] ref_word(int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask
    task automatic chk_quiet(input string nm);
        chk(nm, 32'({req_ready, resp_valid, resp_err, dmem_write, dmem_read}) | resp_rdata |
                32'(dmem_addr) | 32'(dmem_size) | dmem_din, 32'h0);
    endtask
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        else if (dmem_write)
            for (int k = 0; k < 4; k++) if (dmem_size[k]) mem[dmem_addr[AW-1:2]][8*k+:8] <= dmem_din[8*k+:8];
        if (dmem_read) dout <= mem[dmem_addr[AW-1:2]];
    end
    always @(negedge clk) if (chk_en) begin
        rec_t e;
        e = exp_q.size() != 0 ? exp_q.pop_front() : blank(1'b1);
        chk("req_ready", 32'(req_ready), 32'(e.rdy));
        chk("dmem_write", 32'(dmem_write), 32'(e.wr));
        chk("dmem_read", 32'(dmem_read), 32'(e.rd));
        chk("dmem_addr", 32'(dmem_addr), 32'(e.addr));
        chk("dmem_size", 32'(dmem_size), 32'(e.size));
        chk("dmem_din", dmem_din, e.din);
        chk("resp_valid", 32'(resp_valid), 32'(e.rv));
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        if (dmem_write || dmem_read) acc_log.push_back('{dmem_write, dmem_addr, dmem_size, dmem_din});
        if (resp_valid) last_rdata = resp_rdata;
    end
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        rec_t r[2];
        rec_t rs;
        int n, p;
        bit legal, err;
        logic [31:0] v;
        logic [AW-1:0] w0;
        acc_log.delete();
        n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal || (longint'(addr) + longint'(n) - 1 >= longint'(DEPTH * 4));
        r[0] = blank(1'b0);
        r[1] = blank(1'b0);
        rs = blank(1'b0);
        rs.rv = 1'b1;
        rs.err = err;
        v = '0;
        if (!err) begin
            w0 = {addr[AW-1:2], 2'b00};
            r[0].addr = w0;
            r[1].addr = w0 + 12'd4;
            for (int j = 0; j < 4; j++) begin
                p = int'(addr[1:0]) + j;
                r[p/4].din[8*(p%4)+:8] = wd[8*j+:8];
                if (j < n) begin
                    r[p/4].size[p%4] = 1'b1;
                    if (we) ref_mem[int'(addr[AW-1:0]) + j] = wd[8*j+:8];
                    else v[8*j+:8] = ref_mem[int'(addr[AW-1:0]) + j];
                end
            end
            for (int i = 0; i < 2; i++) begin
                r[i].wr = we;
                r[i].rd = !we;
            end
            rs.rdata = we ? 32'h0 : extend(f3, v);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_f3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (err) exp_q.push_back(blank(1'b0));
        else begin
            exp_q.push_back(r[0]);
            if (r[1].size != 0) exp_q.push_back(r[1]);
        end
        exp_q.push_back(rs);
        while (exp_q.size() != 0) @(posedge clk);
    endtask
    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] t;
        logic [31:0] w6;
        for (int i = 0; i < DEPTH; i++) begin
            t = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = t[8*b+:8];
        end
        repeat (3) @(negedge clk);
        chk_quiet("reset_outputs");
        @(posedge clk);
        fill = 1'b0;
        #1 rst = 1'b0;
        chk_en = 1'b1;
        do_req(1, 3'd2, 32'h010, 32'hDEADBEEF);
        chk("sw_acc_count", 32'(acc_log.size()), 1);
        chk("sw_addr", 32'(acc_log[0].addr), 32'h010);
        chk("sw_size", 32'(acc_log[0].size), 32'hF);
        chk("sw_din", acc_log[0].din, 32'hDEADBEEF);
        do_req(0, 3'd2, 32'h010, 32'h0);
        chk("lw_data", last_rdata, 32'hDEADBEEF);
        do_req(1, 3'd0, 32'h013, 32'h80);
        chk("sb_size", 32'(acc_log[0].size), 32'h8);
        chk("sb_din", acc_log[0].din, 32'h80000000);
        do_req(0, 3'd0, 32'h013, 32'h0);
        chk("lb_data", last_rdata, 32'hFFFFFF80);
        do_req(0, 3'd4, 32'h013, 32'h0);
        chk("lbu_data", last_rdata, 32'h00000080);
        do_req(1, 3'd1, 32'h012, 32'hBEEF);
        chk("sh_size", 32'(acc_log[0].size), 32'hC);
        chk("sh_din", acc_log[0].din, 32'hBEEF0000);
        do_req(0, 3'd1, 32'h012, 32'h0);
        chk("lh_data", last_rdata, 32'hFFFFBEEF);
        do_req(0, 3'd5, 32'h012, 32'h0);
        chk("lhu_data", last_rdata, 32'h0000BEEF);
        do_req(1, 3'd2, 32'h016, 32'h11223344);
        chk("split_count", 32'(acc_log.size()), 2);
        chk("split_addr0", 32'(acc_log[0].addr), 32'h014);
        chk("split_size0", 32'(acc_log[0].size), 32'hC);
        chk("split_din0", acc_log[0].din, 32'h33440000);
        chk("split_addr1", 32'(acc_log[1].addr), 32'h018);
        chk("split_size1", 32'(acc_log[1].size), 32'h3);
        chk("split_din1", acc_log[1].din, 32'h00001122);
        do_req(0, 3'd2, 32'h016, 32'h0);
        chk("split_lw", last_rdata, 32'h11223344);
        do_req(0, 3'd2, 32'hFFE, 32'h0);
        chk("err_range_nostrobe", 32'(acc_log.size()), 0);
        do_req(0, 3'd3, 32'h000, 32'h0);
        chk("err_f3_nostrobe", 32'(acc_log.size()), 0);
        // reset taken during the second half of a split store
        w6 = ref_word(6);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h016; req_wdata = 32'hA5B6C7D8;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_acc0_wr", 32'(dmem_write), 1);
        chk("rst_acc0_addr", 32'(dmem_addr), 32'h014);
        chk("rst_acc0_din", dmem_din, 32'hC7D80000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_quiet("rst_mid_outputs");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", 32'(req_ready), 1);
        chk("rst_after_rvalid", 32'(resp_valid), 0);
        ref_mem[32'h016] = 8'hD8;
        ref_mem[32'h017] = 8'hC7;
        chk("rst_word5", mem[5], ref_word(5));
        chk("rst_word6", mem[6], w6);
        chk_en = 1'b1;
        @(posedge clk);
        do_req(0, 3'd2, 32'h014, 32'h0);
        do_req(0, 3'd2, 32'h018, 32'h0);
        for (int it = 0; it < 300; it++) begin
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            a = sel == 0 ? $urandom : sel == 1 ? 32'(4088 + $urandom_range(0, 7)) :
                sel < 5 ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 4095));
            do_req(1'($urandom), 3'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_word(i));
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator that sits between the core's memory stage and the banked byte-lane data memory. It accepts one RV32I load or store request at a time over a valid/ready handshake. It converts the request into byte-enabled word accesses, splitting misaligned accesses that cross a word boundary into two. It aligns store data, and extracts and sign- or zero-extends load data. It returns a single response per request, with an error flag.

Parameters:
DMEM_DEPTH, 1024, memory depth in 32-bit words (must match the data memory)
DMEM_ADDR_WIDTH, 12, byte-address width of the data memory; log2(DMEM_DEPTH*4)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid and ready are both high
req_we_i  input  1  1 = store, 0 = load
req_funct3_i  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-justified
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  32  extended load data; 0 for stores and errors
resp_err_o  output  1  request was rejected; no memory write occurred
dmem_addr_o  output  DMEM_ADDR_WIDTH  word-aligned byte address; bits [1:0] always 0
dmem_write_o  output  1  write strobe
dmem_read_o  output  1  read strobe; data is returned on dmem_dout_i the next cycle and held until the next read
dmem_size_o  output  4  byte-lane enables; bit k selects bits [8k+7:8k]
dmem_din_o  output  32  lane-aligned write data
dmem_dout_i  input  32  read data from memory

Behaviour:
- Reset is synchronous and active-high. Clock is clk_i.
- States: IDLE, ACC0, ACC1, RESP. Reset forces IDLE.
- While rst_i is high, all outputs are 0. After reset: req_ready_o=1 and all other outputs are 0.
- req_ready_o is 1 only in IDLE. In IDLE, valid&ready registers we, funct3, addr and wdata, then moves to ACC0.
- Access size n: 1 for funct3[1:0]=00, 2 for 01, 4 for 10. off = addr[1:0].
- Legal funct3:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
  - anything else is an error.
- Range error: addr + n - 1 >= DMEM_DEPTH*4, computed with 33-bit arithmetic.
- Error path: ACC0 drives no strobes and goes to RESP with resp_err_o=1 and resp_rdata_o=0.
- Byte mask m8 = ((1<<n)-1) << off, 8 bits wide. split = |m8[7:4].
- Store data w64 = {32'b0, wdata} << (8*off).
- ACC0:
  - dmem_addr_o = {addr[W-1:2], 2'b00}, dmem_size_o = m8[3:0], dmem_din_o = w64[31:0].
  - Assert dmem_write_o for stores and dmem_read_o for loads.
  - Next state is ACC1 if split, else RESP.
- ACC1:
  - For loads, register dmem_dout_i as lo_word.
  - Drive dmem_addr_o = first word address + 4, dmem_size_o = m8[7:4], dmem_din_o = w64[63:32], with the same strobe type as ACC0.
  - Next state is RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle.
  - For loads, r64 = split ? {dmem_dout_i, lo_word} : {32'b0, dmem_dout_i}. Then d = r64 >> (8*off).
  - LB/LH sign-extend d[7:0] / d[15:0]. LBU/LHU zero-extend. LW returns d[31:0].
  - Next state is IDLE. A new request can be accepted in the cycle after RESP.
- Latency, counting accept at cycle T:
  - aligned or non-crossing access: resp_valid_o at T+2
  - split access: resp_valid_o at T+3
  - error: resp_valid_o at T+2
- Throughput is one request per 3 or 4 cycles; there is no pipelining.
- Strobes are low in IDLE and RESP. dmem_addr_o, dmem_size_o and dmem_din_o are 0 whenever no strobe is asserted.
- Reset mid-operation returns to IDLE with no response. If reset is taken in ACC1 of a split store, the first half remains written and the second half is not.
- resp_* outputs do not depend on req_* inputs after acceptance; the request is fully registered.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 -> ACC0: addr 0x010, size 1111, din 0xDEADBEEF. Load resp_rdata 0xDEADBEEF, resp_valid at T+2, err 0.
- SB 0x80 @0x013 -> size 1000, din 0x80000000. LB @0x013 -> 0xFFFFFF80. LBU @0x013 -> 0x00000080.
- SH 0xBEEF @0x012, then LH and LHU @0x012 -> size 1100, din 0xBEEF0000. Results 0xFFFFBEEF and 0x0000BEEF.
- SW 0x11223344 @0x016 -> two writes: addr 0x014 size 1100 din 0x33440000, then addr 0x018 size 0011 din 0x00001122. LW @0x016 -> 0x11223344 at T+3.
- LW @0xFFE and funct3=011 load @0x0 -> resp_err 1, rdata 0, no dmem strobe in any cycle.
- Assert rst_i during ACC1 of the split SW above -> next cycle IDLE, req_ready 1, no resp_valid. Word 0x014 is updated; word 0x018 is unchanged.
